// File: rtl/sid_envelope_regs_pkg.sv
// Shared SID types and envelope register-map constants used by the envelope
// register front end and its decoder.
package sid;

  typedef logic [3:0] cycle_t;
  typedef logic [7:0] reg8_t;
  typedef logic [3:0] reg4_t;

  typedef struct packed {
    logic  gate;
    reg4_t attack;
    reg4_t decay;
    reg4_t sustain;
    reg4_t release_;
  } envelope_reg_t;

  localparam int ENV_OFS_CTRL    = 4;
  localparam int ENV_OFS_AD      = 5;
  localparam int ENV_OFS_SR      = 6;
  localparam int ENV_FIRST_CYCLE = 6;

endpackage

// File: rtl/sid_envelope_regs_if.sv
// CPU write bus into the envelope register store: strobe, chip select,
// SID register address and data.
interface sid_envelope_regs_if;
  import sid::*;

  logic       we;
  logic       cs;
  logic [4:0] addr;
  reg8_t      data;

  modport master (output we, cs, addr, data);
  modport slave  (input  we, cs, addr, data);

endinterface

// File: rtl/sid_envelope_regs_decode.sv
// Combinational decode of chip select and SID address into a voice index
// and per-field write enables for the envelope registers.
module sid_envelope_decode
  import sid::*;
(
  input  logic       i_cs,
  input  logic [4:0] i_addr,
  output logic [2:0] o_voice,
  output logic       o_ctrlEn,
  output logic       o_adEn,
  output logic       o_srEn
);

  logic [1:0] w_group;
  logic [4:0] w_offset;
  logic       w_valid;

  // Each voice owns 7 consecutive addresses; 0x15 and above map to no voice.
  always_comb begin
    w_group  = 2'd0;
    w_offset = i_addr;
    w_valid  = 1'b1;
    if (i_addr < 5'd7) begin
      w_group  = 2'd0;
      w_offset = i_addr;
    end else if (i_addr < 5'd14) begin
      w_group  = 2'd1;
      w_offset = i_addr - 5'd7;
    end else if (i_addr < 5'd21) begin
      w_group  = 2'd2;
      w_offset = i_addr - 5'd14;
    end else begin
      w_valid  = 1'b0;
    end
    o_voice  = i_cs ? (3'(w_group) + 3'd3) : 3'(w_group);
    o_ctrlEn = w_valid && (w_offset == 5'(ENV_OFS_CTRL));
    o_adEn   = w_valid && (w_offset == 5'(ENV_OFS_AD));
    o_srEn   = w_valid && (w_offset == 5'(ENV_OFS_SR));
  end

endmodule

// File: rtl/sid_envelope_regs.sv
// Double-buffered envelope register store for both SID chips, one voice per
// pipeline slot. ENV3 capture is present only when ENV3_READBACK_EN is defined.
module sid_envelope_regs
  import sid::*;
#(
  parameter int VOICES       = 6,
  parameter int COMMIT_CYCLE = 4
) (
  input  logic                clk,
  input  logic                res_n,
  input  cycle_t              cycle,
  sid_envelope_regs_if.slave  bus,
  input  reg8_t               env,
  output envelope_reg_t       ereg,
  output reg8_t [1:0]         env3
);

  localparam cycle_t SLOT_LOAD_FIRST = cycle_t'(ENV_FIRST_CYCLE - 1);
  localparam cycle_t SLOT_LOAD_LAST  = cycle_t'(ENV_FIRST_CYCLE + VOICES - 2);

  logic [2:0]    w_voice;
  logic          w_ctrlEn;
  logic          w_adEn;
  logic          w_srEn;
  logic          w_commit;
  logic          w_slotLoad;
  logic [2:0]    w_slotIdx;
  envelope_reg_t w_shadowNext [VOICES];
  envelope_reg_t r_shadow     [VOICES];
  envelope_reg_t r_live       [VOICES];
  envelope_reg_t r_ereg;

  sid_envelope_decode u_decode (
    .i_cs     (bus.cs),
    .i_addr   (bus.addr),
    .o_voice  (w_voice),
    .o_ctrlEn (w_ctrlEn),
    .o_adEn   (w_adEn),
    .o_srEn   (w_srEn)
  );

  assign w_commit   = (cycle == cycle_t'(COMMIT_CYCLE));
  assign w_slotLoad = (cycle >= SLOT_LOAD_FIRST) && (cycle <= SLOT_LOAD_LAST);
  assign w_slotIdx  = 3'(cycle - SLOT_LOAD_FIRST);

  // The commit loads from the merged next-shadow so a write on the commit
  // edge lands in this SID cycle rather than the next.
  always_comb begin
    for (int v = 0; v < VOICES; v++) begin
      w_shadowNext[v] = r_shadow[v];
      if (bus.we && (w_voice == 3'(v))) begin
        if (w_ctrlEn) w_shadowNext[v].gate = bus.data[0];
        if (w_adEn) begin
          w_shadowNext[v].attack = bus.data[7:4];
          w_shadowNext[v].decay  = bus.data[3:0];
        end
        if (w_srEn) begin
          w_shadowNext[v].sustain  = bus.data[7:4];
          w_shadowNext[v].release_ = bus.data[3:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      for (int v = 0; v < VOICES; v++) begin
        r_shadow[v] <= '0;
        r_live[v]   <= '0;
      end
      r_ereg <= '0;
    end else begin
      for (int v = 0; v < VOICES; v++) begin
        r_shadow[v] <= w_shadowNext[v];
        if (w_commit) r_live[v] <= w_shadowNext[v];
      end
      if (w_slotLoad) r_ereg <= r_live[w_slotIdx];
    end
  end

  assign ereg = r_ereg;

`ifdef ENV3_READBACK_EN
  localparam cycle_t ENV3_CHIP0_CYCLE = cycle_t'(ENV_FIRST_CYCLE + 2);
  localparam cycle_t ENV3_CHIP1_CYCLE = cycle_t'(ENV_FIRST_CYCLE + 5);

  reg8_t [1:0] r_env3;

  // Voice 3 of each chip sits in slots 2 and 5 of the envelope pipeline.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_env3 <= '0;
    end else begin
      if (cycle == ENV3_CHIP0_CYCLE) r_env3[0] <= env;
      if (cycle == ENV3_CHIP1_CYCLE) r_env3[1] <= env;
    end
  end

  assign env3 = r_env3;
`else
  logic w_unusedEnv;

  assign w_unusedEnv = ^env;
  assign env3        = '0;
`endif

endmodule

// File: tb/tb_sid_envelope_regs.sv
// Randomized and directed bench for sid_envelope_regs against a field-level
// model of the shadow/live register store and the slot schedule.
module tb_sid_envelope_regs;
  import sid::*;

  localparam int SID_CYCLE_LEN = 12;

  logic          clk;
  logic          res_n;
  cycle_t        cycle;
  reg8_t         env;
  envelope_reg_t ereg;
  reg8_t [1:0]   env3;

  sid_envelope_regs_if bus ();

  sid_envelope_regs #(.VOICES(6), .COMMIT_CYCLE(4)) dut (
    .clk   (clk),
    .res_n (res_n),
    .cycle (cycle),
    .bus   (bus),
    .env   (env),
    .ereg  (ereg),
    .env3  (env3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  envelope_reg_t mShadow [6];
  envelope_reg_t mLive   [6];
  envelope_reg_t expEreg;
  reg8_t [1:0]   expEnv3;

  task automatic modelReset();
    for (int v = 0; v < 6; v++) begin
      mShadow[v] = '0;
      mLive[v]   = '0;
    end
    expEreg = '0;
    expEnv3 = '0;
  endtask

  // One clk: model the edge from the inputs in force, then advance the cycle
  // counter and release the write strobe 1 ns after the edge.
  task automatic tick();
    int edgeCycle;
    int v;
    int ofs;
    @(posedge clk);
    edgeCycle = int'(cycle);
    if (!res_n) begin
      modelReset();
    end else begin
      if (bus.we && (int'(bus.addr) <= 20)) begin
        v   = 3 * int'(bus.cs) + int'(bus.addr) / 7;
        ofs = int'(bus.addr) % 7;
        case (ofs)
          4: mShadow[v].gate = bus.data[0];
          5: begin
            mShadow[v].attack = bus.data[7:4];
            mShadow[v].decay  = bus.data[3:0];
          end
          6: begin
            mShadow[v].sustain  = bus.data[7:4];
            mShadow[v].release_ = bus.data[3:0];
          end
          default: ;
        endcase
      end
      if (edgeCycle == 4) mLive = mShadow;
`ifdef ENV3_READBACK_EN
      if (edgeCycle == 8)  expEnv3[0] = env;
      if (edgeCycle == 11) expEnv3[1] = env;
`endif
    end
    #1;
    cycle  = cycle_t'((edgeCycle + 1) % SID_CYCLE_LEN);
    bus.we = 1'b0;
    env    = reg8_t'($urandom);
    if (res_n && int'(cycle) >= 6) expEreg = mLive[int'(cycle) - 6];
  endtask

  task automatic waitCycle(input int target);
    for (int i = 0; i < SID_CYCLE_LEN && int'(cycle) != target; i++) tick();
  endtask

  task automatic applyStimulus(input logic cs, input logic [4:0] addr, input reg8_t data);
    bus.we   = 1'b1;
    bus.cs   = cs;
    bus.addr = addr;
    bus.data = data;
    tick();
  endtask

  task automatic test_reset();
    #2 res_n = 1'b0;
    modelReset();
    #1;
    vectors++;
    if (ereg !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_ereg: got %h expected %h", ereg, 21'h0);
    end
    vectors++;
    if (env3 !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_env3: got %h expected %h", env3, 16'h0);
    end
    tick();
    tick();
    res_n = 1'b1;
    waitCycle(0);
    for (int i = 0; i < SID_CYCLE_LEN; i++) begin
      tick();
      vectors++;
      if (ereg !== '0) begin
        miscompares++;
        $display("[TB] FAIL reset_slot cycle %0d: got %h expected %h", cycle, ereg, 21'h0);
      end
    end
  endtask

  task automatic test_ad_sr();
    envelope_reg_t want;
    want = '{gate: 1'b0, attack: 4'h9, decay: 4'hA, sustain: 4'h5, release_: 4'hC};
    waitCycle(0);
    applyStimulus(1'b0, 5'h0C, 8'h9A);
    applyStimulus(1'b0, 5'h0D, 8'h5C);
    waitCycle(6);
    vectors++;
    if (ereg !== '0) begin
      miscompares++;
      $display("[TB] FAIL ad_sr_slot0: got %h expected %h", ereg, 21'h0);
    end
    waitCycle(7);
    vectors++;
    if (ereg !== want) begin
      miscompares++;
      $display("[TB] FAIL ad_sr_slot1: got %h expected %h", ereg, want);
    end
  endtask

  task automatic test_gate_commit_edge();
    waitCycle(4);
    applyStimulus(1'b1, 5'h0B, 8'h01);
    waitCycle(10);
    vectors++;
    if (ereg.gate !== 1'b1 || ereg !== expEreg) begin
      miscompares++;
      $display("[TB] FAIL gate_commit_edge: got %h expected %h (gate 1)", ereg, expEreg);
    end
  endtask

  task automatic test_gate_pulse();
    waitCycle(0);
    applyStimulus(1'b0, 5'h04, 8'h01);
    waitCycle(2);
    applyStimulus(1'b0, 5'h04, 8'h00);
    repeat (3) begin
      tick();
      waitCycle(6);
      vectors++;
      if (ereg.gate !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL gate_pulse_lost: got %b expected %b", ereg.gate, 1'b0);
      end
    end
  endtask

  task automatic test_ignored();
    envelope_reg_t saved [6];
    saved = mLive;
    waitCycle(0);
    applyStimulus(1'b0, 5'h15, 8'hFF);
    applyStimulus(1'b1, 5'h1F, 8'hFF);
    applyStimulus(1'b0, 5'h02, 8'hFF);
    applyStimulus(1'b1, 5'h09, 8'hFF);
    applyStimulus(1'b0, 5'h10, 8'hFF);
    repeat (3 * SID_CYCLE_LEN) begin
      tick();
      if (int'(cycle) >= 6) begin
        vectors++;
        if (ereg !== saved[int'(cycle) - 6]) begin
          miscompares++;
          $display("[TB] FAIL ignored_addr cycle %0d: got %h expected %h",
                   cycle, ereg, saved[int'(cycle) - 6]);
        end
      end
    end
  endtask

  task automatic test_env3();
    reg8_t [1:0] want;
`ifdef ENV3_READBACK_EN
    want = {8'hC1, 8'h37};
`else
    want = '0;
`endif
    waitCycle(8);
    env = 8'h37;
    tick();
    waitCycle(11);
    env = 8'hC1;
    tick();
    vectors++;
    if (env3 !== want) begin
      miscompares++;
      $display("[TB] FAIL env3_capture: got %h expected %h", env3, want);
    end
    waitCycle(7);
    vectors++;
    if (env3 !== want || env3 !== expEnv3) begin
      miscompares++;
      $display("[TB] FAIL env3_stable: got %h expected %h", env3, want);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40 * SID_CYCLE_LEN; i++) begin
      bus.we   = ($urandom_range(0, 2) != 0);
      bus.cs   = 1'($urandom);
      bus.addr = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(21, 31))
                                             : 5'($urandom_range(0, 20));
      bus.data = reg8_t'($urandom);
      env      = reg8_t'($urandom);
      tick();
      vectors++;
      if (ereg !== expEreg) begin
        miscompares++;
        $display("[TB] FAIL random_ereg step %0d cycle %0d: got %h expected %h",
                 i, cycle, ereg, expEreg);
      end
      vectors++;
      if (env3 !== expEnv3) begin
        miscompares++;
        $display("[TB] FAIL random_env3 step %0d cycle %0d: got %h expected %h",
                 i, cycle, env3, expEnv3);
      end
    end
  endtask

  task automatic test_reset_midslot();
    waitCycle(0);
    for (int v = 0; v < 6; v++) begin
      applyStimulus(1'(v / 3), 5'((v % 3) * 7 + 4), 8'h01);
      applyStimulus(1'(v / 3), 5'((v % 3) * 7 + 5), reg8_t'($urandom_range(1, 255)));
      applyStimulus(1'(v / 3), 5'((v % 3) * 7 + 6), reg8_t'($urandom_range(1, 255)));
    end
    waitCycle(4);
    tick();
    waitCycle(8);
    vectors++;
    if (ereg !== expEreg || ereg.gate !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midslot_programmed: got %h expected %h", ereg, expEreg);
    end
    #3 res_n = 1'b0;
    modelReset();
    #1;
    vectors++;
    if (ereg !== '0) begin
      miscompares++;
      $display("[TB] FAIL midslot_reset_ereg: got %h expected %h", ereg, 21'h0);
    end
    vectors++;
    if (env3 !== '0) begin
      miscompares++;
      $display("[TB] FAIL midslot_reset_env3: got %h expected %h", env3, 16'h0);
    end
    #2 res_n = 1'b1;
    repeat (2 * SID_CYCLE_LEN) begin
      tick();
      vectors++;
      if (ereg !== '0 || ereg !== expEreg) begin
        miscompares++;
        $display("[TB] FAIL midslot_after_reset cycle %0d: got %h expected %h",
                 cycle, ereg, 21'h0);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    res_n       = 1'b1;
    cycle       = '0;
    env         = '0;
    bus.we      = 1'b0;
    bus.cs      = 1'b0;
    bus.addr    = '0;
    bus.data    = '0;
    modelReset();
    $display("[TB] starting sid_envelope_regs bench");
    test_reset();
    test_ad_sr();
    test_gate_commit_edge();
    test_gate_pulse();
    test_ignored();
    test_env3();
    test_random();
    test_reset_midslot();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
